// File: rtl/encoder_8_3_queue.sv
// Registered 8-to-3 encoder with a pending-request buffer and valid/ready output.
// Define ENCODER_8_3_RR_EN for round-robin selection; otherwise the highest pending index wins.
module encoder_8_3_queue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] y,
  output logic [7:0] pend,
  output logic [3:0] count,
  output logic       err
);

  typedef enum logic {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [7:0] p_q, p_next, p_d, g;
  logic [2:0] y_q, y_next, sel_idx;
  logic       err_q, err_next;
  logic       fire, dup;

  assign fire   = (state == SHOW) && out_ready;
  assign g      = fire ? (8'b1 << y_q) : 8'b0;
  assign p_next = (p_q & ~g) | req;
  // A bit being fired this cycle is re-armed by req, not counted as a duplicate.
  assign dup    = |(req & p_q & ~g);

`ifdef ENCODER_8_3_RR_EN
  logic [2:0] last_q, last_eff, cand;
  logic       found;

  // The index firing this cycle is already the most recent one for the next search.
  assign last_eff = fire ? y_q : last_q;

  always_comb begin
    sel_idx = 3'd0;
    cand    = 3'd0;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_eff - 3'(k);
      if (!found && p_next[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= 3'd0;
    else if (!clr && fire)
      last_q <= y_q;
  end
`else
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (p_next[i]) sel_idx = 3'(i);
  end
`endif

  // NOTE: every output of this block is given a default first, so no path leaves a latch.
  always_comb begin
    state_next = state;
    y_next     = y_q;
    p_d        = p_next;
    err_next   = err_q | dup;
    if (clr) begin
      state_next = EMPTY;
      y_next     = 3'd0;
      p_d        = 8'd0;
      err_next   = 1'b0;
    end else if (state == EMPTY || fire) begin
      if (p_next != 8'd0) begin
        state_next = SHOW;
        y_next     = sel_idx;
      end else begin
        state_next = EMPTY;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      y_q   <= 3'd0;
      p_q   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      y_q   <= y_next;
      p_q   <= p_d;
      err_q <= err_next;
    end
  end

  assign out_valid = (state == SHOW);
  assign y         = y_q;
  assign pend      = p_q;
  assign err       = err_q;
  assign count     = 4'($countones(p_q));

endmodule

// File: tb/tb_encoder_8_3_queue.sv
// Self-checking bench for encoder_8_3_queue: directed scenarios plus random traffic
// compared against a behavioural model of the pending set and selection rule.
module tb_encoder_8_3_queue;

  logic       clk = 1'b0;
  logic       rst_n, clr, out_ready, out_valid, err;
  logic [7:0] req, pend;
  logic [2:0] y;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit [7:0] m_p;
  bit [2:0] m_y, m_last;
  bit       m_v, m_err;

  encoder_8_3_queue dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .pend(pend), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next index to present from pending set p; lst is the most recently fired index.
  function automatic bit [2:0] pick(input bit [7:0] p, input bit [2:0] lst);
`ifdef ENCODER_8_3_RR_EN
    for (int k = 1; k <= 8; k++) begin
      int idx = (int'(lst) + 8 - k) % 8;
      if (p[idx]) return 3'(idx);
    end
`else
    for (int i = 7; i >= 0; i--)
      if (p[i]) return 3'(i);
`endif
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_p = 0; m_y = 0; m_v = 0; m_err = 0; m_last = 0;
  endtask

  task automatic model_edge();
    bit       f;
    bit [7:0] gone, nxt;
    bit [2:0] lst;
    f    = m_v && out_ready;
    gone = f ? (8'd1 << m_y) : 8'd0;
    nxt  = (m_p & ~gone) | req;
    if (clr) begin
      m_p = 0; m_v = 0; m_y = 0; m_err = 0;
    end else begin
      if ((req & m_p & ~gone) != 0) m_err = 1;
      lst = f ? m_y : m_last;
      if (f) m_last = m_y;
      m_p = nxt;
      if (!m_v || f) begin
        m_v = (nxt != 0);
        if (nxt != 0) m_y = pick(nxt, lst);
      end
    end
  endtask

  task automatic compare_all();
    check("valid", out_valid, m_v);
    if (m_v) check("y", y, m_y);
    check("pend", pend, m_p);
    check("count", count, $countones(m_p));
    check("err", err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_y", y, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; req = 0; out_ready = 0;
    do_reset();

    // Drain three requests back-to-back
    req = 8'b1010_0100; out_ready = 1;
    step(); check("drain_y0", y, 7); check("drain_c0", count, 3);
    req = 0;
    step(); check("drain_y1", y, 5); check("drain_c1", count, 2);
    step(); check("drain_y2", y, 2); check("drain_c2", count, 1);
    step(); check("drain_v3", out_valid, 0); check("drain_c3", count, 0);

    // Backpressure: presented index is frozen despite a higher request
    out_ready = 0; req = 8'h01;
    step(); check("bp_y0", y, 0);
    req = 8'h80;
    step(); check("bp_y1", y, 0); check("bp_pend", pend, 8'h81); check("bp_cnt", count, 2);
    req = 0; out_ready = 1;
    step(); check("bp_y2", y, 7);
    step(); check("bp_empty", out_valid, 0);

    // Duplicate request sets the sticky error
    out_ready = 0; req = 8'h08;
    step();
    step(); check("dup_err", err, 1);
    req = 0;
    step(); check("dup_sticky", err, 1);
    clr = 1;
    step(); check("clr_err", err, 0); check("clr_y", y, 0);
    clr = 0;

    // Re-arm in the fire cycle re-presents the index without error
    req = 8'h08;
    step(); check("rearm_y0", y, 3);
    out_ready = 1;
    step(); check("rearm_y1", y, 3); check("rearm_v", out_valid, 1); check("rearm_err", err, 0);
    req = 0;
    step(); check("rearm_empty", out_valid, 0);

    // Clear wins over a simultaneous request
    out_ready = 0; req = 8'h3C;
    step(); check("clr_v0", out_valid, 1);
    clr = 1; req = 8'h01;
    step(); check("clr_pend", pend, 0); check("clr_v1", out_valid, 0); check("clr_e", err, 0);
    clr = 0; req = 0;

    // Priority mode from a fresh reset
    do_reset();
    req = 8'h81; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef ENCODER_8_3_RR_EN
      check("prio_y", y, (i % 2 == 0) ? 7 : 0);
`else
      check("prio_y", y, 7);
`endif
    end
    req = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 0;

    // Asynchronous reset in the middle of a full SHOW
    out_ready = 0; req = 8'hFF;
    step(); step();
    check("full_pend", pend, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_v", out_valid, 0); check("arst_y", y, 0);
    check("arst_pend", pend, 0); check("arst_cnt", count, 0); check("arst_err", err, 0);
    req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
